// File: rtl/imm_instr_encoder.sv
// Packs an immediate plus register/opcode fields into an RV32I instruction word.
// Two-stage valid/ready pipeline with delivered-word and error-word counters.
module imm_instr_encoder #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [31:0]      in_imm,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] TypeR = 3'd0;
  localparam logic [2:0] TypeI = 3'd1;
  localparam logic [2:0] TypeS = 3'd2;
  localparam logic [2:0] TypeB = 3'd3;
  localparam logic [2:0] TypeU = 3'd4;
  localparam logic [2:0] TypeJ = 3'd5;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_type_q, s1_type_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  logic [6:0]       s1_opcode_q, s1_opcode_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [4:0]       s1_rs1_q, s1_rs1_d;
  logic [4:0]       s1_rs2_q, s1_rs2_d;
  logic [2:0]       s1_funct3_q, s1_funct3_d;
  logic [6:0]       s1_funct7_q, s1_funct7_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q, s2_err_d;

  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             s2_load;
  logic             deliver;
  logic [31:0]      enc_word;
  logic             enc_bad;
  logic             fit_12, fit_13, fit_21;

  // Representable when the bits above the field's sign bit all match it.
  assign fit_12 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
  assign fit_13 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
  assign fit_21 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

  always_comb begin
    enc_word = 32'h0;
    enc_bad  = 1'b0;
    case (s1_type_q)
      TypeR: enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      TypeI: begin
        enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        enc_bad  = ~fit_12;
      end
      TypeS: begin
        enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                    s1_opcode_q};
        enc_bad  = ~fit_12;
      end
      TypeB: begin
        enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
        enc_bad  = ~fit_13 | s1_imm_q[0];
      end
      TypeU: begin
        enc_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
        enc_bad  = |s1_imm_q[11:0];
      end
      TypeJ: begin
        enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q,
                    s1_opcode_q};
        enc_bad  = ~fit_21 | s1_imm_q[0];
      end
      default: enc_bad = 1'b1;
    endcase
  end

  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign deliver  = s2_valid_q & out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_type_d   = s1_type_q;
    s1_imm_d    = s1_imm_q;
    s1_opcode_d = s1_opcode_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_funct3_d = s1_funct3_q;
    s1_funct7_d = s1_funct7_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_type_d   = in_type;
        s1_imm_d    = in_imm;
        s1_opcode_d = in_opcode;
        s1_rd_d     = in_rd;
        s1_rs1_d    = in_rs1;
        s1_rs2_d    = in_rs2;
        s1_funct3_d = in_funct3;
        s1_funct7_d = in_funct7;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = enc_bad ? NOP_WORD : enc_word;
        s2_err_d   = enc_bad;
      end
    end

    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (clr_cnt) begin
      enc_count_d = '0;
      err_count_d = '0;
    end else if (deliver) begin
      enc_count_d = enc_count_q + 1'b1;
      if (s2_err_q) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_type_q   <= '0;
      s1_imm_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_type_q   <= s1_type_d;
      s1_imm_q    <= s1_imm_d;
      s1_opcode_q <= s1_opcode_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the pipeline's immediate decode path. It accepts a 32-bit immediate value, an immediate type code and the register/opcode fields, and packs them into a 32-bit RV32I instruction word.
- It checks that the immediate is representable in the selected format.
- It sits in the debug/test-program loader path, ahead of instruction memory writes, and is a two-stage valid/ready pipeline with status counters.

Parameters:
- CNT_W, 16, width of the encoded and error counters.
- NOP_WORD, 32'h00000013, word emitted in place of an unencodable instruction.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- in_type  input  3  immediate type; codes are the `RTYPE/`ITYPE/`STYPE/`BTYPE/`UTYPE/`JTYPE defines in Parameters.v.
- in_imm  input  32  immediate as the actual signed/absolute value, i.e. what the decoder would output.
- in_opcode  input  7  opcode field.
- in_rd  input  5  rd field.
- in_rs1  input  5  rs1 field.
- in_rs2  input  5  rs2 field.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field (R-type only).
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the output word.
- out_instr  output  32  encoded instruction, or NOP_WORD on error.
- out_err  output  1  range/alignment/type error for this word.
- clr_cnt  input  1  synchronous clear of both counters.
- enc_count  output  CNT_W  words delivered (out_valid && out_ready), error words included.
- err_count  output  CNT_W  error words delivered.

Behaviour:
- Reset: out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. Both stages are emptied. rst mid-transfer discards any in-flight word, and nothing is counted for it.
- Pipeline structure:
  - Stage 1 registers the request.
  - Stage 2 holds the encoded result and drives out_*.
- Stage 2 loads when it is empty or when out_ready=1.
- Stage 1 advances whenever stage 2 loads.
- in_ready = !s1_valid || s2_load. It is combinational and independent of in_valid.
- Transfer occurs on in_valid && in_ready.
- Latency: a word accepted at edge k has out_valid=1 after edge k+1.
- Throughput is one word per cycle while out_ready=1. No bubble is inserted and no word is lost or duplicated under any out_ready pattern.
- out_instr, out_err and out_valid hold stable while out_valid && !out_ready.
- Encoding (imm = in_imm):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored, never an error.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error rules (out_err=1, out_instr=NOP_WORD):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - Any other type code.
- Counters:
  - Increment on the delivery handshake only.
  - Wrap modulo 2^CNT_W.
  - clr_cnt has priority over a same-cycle increment: the result is 0 and that delivery is not counted.
  - rst clears both counters.

Test Plan:
- ITYPE, imm=5, opcode=7'b0010011, rd=1, rs1=0, funct3=0, out_ready=1 → out_instr=32'h00500093, out_err=0, out_valid exactly 2 edges after acceptance, enc_count=1.
- Back-to-back stream with out_ready=1:
  - STYPE imm=8, rs1=1, rs2=2, funct3=3'b010, opcode=7'b0100011 → 32'h0020A423.
  - BTYPE imm=-4, rs1=rs2=0, funct3=0, opcode=7'b1100011 → 32'hFE000EE3.
  - JTYPE imm=32'h800, rd=1, opcode=7'b1101111 → 32'h001000EF.
  - UTYPE imm=32'h12345000, rd=5, opcode=7'b0110111 → 32'h123452B7.
  - Expect one output per cycle, in order.
- Error cases:
  - ITYPE imm=2048 → 32'h00000013 with out_err=1.
  - BTYPE imm=3 → error.
  - UTYPE imm=32'h1 → error.
  - Type code 3'b111 → error.
  - After all four, err_count=4 and enc_count=4.
- Backpressure: stream 6 words while out_ready follows the pattern 1,0,0,1,0,1,1,1,… → in_ready drops once both stages are full, output holds stable while stalled, and all 6 words arrive in order with none dropped or duplicated.
- rst asserted for 1 cycle while both stages are full → next cycle out_valid=0, in_ready=1, counters=0, and the following request encodes correctly.
- clr_cnt asserted in the same cycle as a delivery handshake → counters read 0 afterwards. With CNT_W=4 and 17 deliveries, enc_count=1 (wrap).
